pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the P7 five-stage MIPS core (D/E/M/W boundaries).

---
 rtl/pipe_stage_reg.sv | 96 +++++++++
 tb/tb_pipe_stage_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the five-stage core: one instance per D/E/M/W boundary.
// Handles stall (hold), flush (bubble), exception request (handler bubble) and stall-cycle counting.
module pipe_stage_reg #(
  parameter int          PAYLOAD_W     = 64,
  parameter int          TNEW_W        = 2,
  parameter int          EXC_W         = 5,
  parameter logic [31:0] HANDLER_PC    = 32'h0000_4180,
  parameter bit          DEC_TNEW      = 1'b1,
  parameter bit          FLUSH_KEEP_PC = 1'b1,
  parameter int          CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [31:0]          in_pc,
  input  logic                 in_bd,
  input  logic [TNEW_W-1:0]    in_tnew,
  input  logic [EXC_W-1:0]     in_exc,
  input  logic [EXC_W-1:0]     in_new_exc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_pc8,
  output logic                 out_bd,
  output logic [TNEW_W-1:0]    out_tnew,
  output logic [EXC_W-1:0]     out_exc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     stall_cnt
);
  typedef struct packed {
    logic                 valid;
    logic [31:0]          pc;
    logic                 bd;
    logic [TNEW_W-1:0]    tnew;
    logic [EXC_W-1:0]     exc;
    logic [PAYLOAD_W-1:0] payload;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  slot_t            cur, load_slot, flush_slot, handler_slot;
  logic [CNT_W-1:0] cnt;

  // Earliest exception wins; bubbles never carry an exception.
  always_comb begin
    load_slot         = '0;
    load_slot.valid   = in_valid;
    load_slot.pc      = in_pc;
    load_slot.bd      = in_bd;
    load_slot.payload = in_payload;
    if (in_valid) load_slot.exc = (in_exc != '0) ? in_exc : in_new_exc;
    if (DEC_TNEW) load_slot.tnew = (in_tnew != '0) ? in_tnew - TNEW_W'(1) : '0;
    else          load_slot.tnew = in_tnew;
  end

  // Keeping the PC in a flush bubble lets a later exception still report a correct EPC.
  always_comb begin
    flush_slot = '0;
    if (FLUSH_KEEP_PC) begin
      flush_slot.pc = in_pc;
      flush_slot.bd = in_bd;
    end
    handler_slot    = '0;
    handler_slot.pc = HANDLER_PC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= '0;
      cnt <= '0;
    end else if (req) begin
      cur <= handler_slot;
      cnt <= '0;
    end else if (stall) begin
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end else if (flush) begin
      cur <= flush_slot;
      cnt <= '0;
    end else begin
      cur <= load_slot;
      cnt <= '0;
    end
  end

  assign out_valid   = cur.valid;
  assign out_pc      = cur.pc;
  assign out_pc8     = cur.pc + 32'd8;
  assign out_bd      = cur.bd;
  assign out_tnew    = cur.tnew;
  assign out_exc     = cur.exc;
  assign out_payload = cur.payload;
  assign stall_cnt   = cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (default and no-keep/no-decrement) checked
// every cycle against a spec-level model, plus directed literal checks.
module tb_pipe_stage_reg;
  logic        clk = 0, reset = 0, req = 0, stall = 0, flush = 0;
  logic        in_valid = 0, in_bd = 0;
  logic [31:0] in_pc = 0;
  logic [1:0]  in_tnew = 0;
  logic [4:0]  in_exc = 0, in_new_exc = 0;
  logic [63:0] in_payload = 0;

  logic        o_valid[2], o_bd[2];
  logic [31:0] o_pc[2], o_pc8[2];
  logic [1:0]  o_tnew[2];
  logic [4:0]  o_exc[2];
  logic [63:0] o_payload[2];
  logic [7:0]  o_cnt[2];

  int checks = 0, errors = 0;
  bit started = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u0 (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_tnew(in_tnew),
    .in_exc(in_exc), .in_new_exc(in_new_exc), .in_payload(in_payload),
    .out_valid(o_valid[0]), .out_pc(o_pc[0]), .out_pc8(o_pc8[0]), .out_bd(o_bd[0]),
    .out_tnew(o_tnew[0]), .out_exc(o_exc[0]), .out_payload(o_payload[0]), .stall_cnt(o_cnt[0]));

  pipe_stage_reg #(.DEC_TNEW(1'b0), .FLUSH_KEEP_PC(1'b0)) u1 (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_tnew(in_tnew),
    .in_exc(in_exc), .in_new_exc(in_new_exc), .in_payload(in_payload),
    .out_valid(o_valid[1]), .out_pc(o_pc[1]), .out_pc8(o_pc8[1]), .out_bd(o_bd[1]),
    .out_tnew(o_tnew[1]), .out_exc(o_exc[1]), .out_payload(o_payload[1]), .stall_cnt(o_cnt[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: what each register slot must hold, from the rules for each cycle.
  bit          m_valid[2], m_bd[2];
  longint      m_pc[2];
  int          m_tnew[2], m_exc[2], m_cnt[2];
  logic [63:0] m_payload[2];
  localparam bit KEEP[2] = '{1'b1, 1'b0};
  localparam bit DEC[2]  = '{1'b1, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset || req) begin
        m_valid[k] = 0; m_bd[k] = 0; m_tnew[k] = 0; m_exc[k] = 0;
        m_payload[k] = 0; m_cnt[k] = 0;
        m_pc[k] = reset ? 0 : 'h4180;
      end else if (stall) begin
        m_cnt[k] = (m_cnt[k] >= 255) ? 255 : m_cnt[k] + 1;
      end else if (flush) begin
        m_valid[k] = 0; m_tnew[k] = 0; m_exc[k] = 0; m_payload[k] = 0; m_cnt[k] = 0;
        m_pc[k] = KEEP[k] ? longint'(in_pc) : 0;
        m_bd[k] = KEEP[k] ? in_bd : 0;
      end else begin
        m_valid[k] = in_valid; m_pc[k] = in_pc; m_bd[k] = in_bd;
        m_payload[k] = in_payload; m_cnt[k] = 0;
        if (!in_valid)        m_exc[k] = 0;
        else if (in_exc != 0) m_exc[k] = in_exc;
        else                  m_exc[k] = in_new_exc;
        if (DEC[k]) m_tnew[k] = (int'(in_tnew) > 0) ? int'(in_tnew) - 1 : 0;
        else        m_tnew[k] = in_tnew;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d valid", k), 64'(o_valid[k]), 64'(m_valid[k]));
        chk($sformatf("u%0d pc", k), 64'(o_pc[k]), 64'(m_pc[k]));
        chk($sformatf("u%0d pc8", k), 64'(o_pc8[k]), 64'((m_pc[k] + 8) % 64'h1_0000_0000));
        chk($sformatf("u%0d bd", k), 64'(o_bd[k]), 64'(m_bd[k]));
        chk($sformatf("u%0d tnew", k), 64'(o_tnew[k]), 64'(m_tnew[k]));
        chk($sformatf("u%0d exc", k), 64'(o_exc[k]), 64'(m_exc[k]));
        chk($sformatf("u%0d payload", k), o_payload[k], m_payload[k]);
        chk($sformatf("u%0d stall_cnt", k), 64'(o_cnt[k]), 64'(m_cnt[k]));
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input bit v, input logic [31:0] pc, input bit bd, input logic [1:0] t,
                      input logic [4:0] e, input logic [4:0] ne, input logic [63:0] p);
    in_valid = v; in_pc = pc; in_bd = bd; in_tnew = t; in_exc = e; in_new_exc = ne; in_payload = p;
  endtask

  initial begin
    reset = 1; cyc();
    started = 1;
    chk("rst valid", 64'(o_valid[0]), 0);
    chk("rst pc", 64'(o_pc[0]), 0);
    chk("rst pc8", 64'(o_pc8[0]), 8);
    chk("rst cnt", 64'(o_cnt[0]), 0);
    stall = 1; cyc();
    chk("rst+stall cnt", 64'(o_cnt[0]), 0);
    chk("rst+stall pc8", 64'(o_pc8[0]), 8);
    reset = 0; stall = 0;

    load(1, 32'h3000, 0, 2, 0, 4, 64'hDEAD_BEEF_0000_0001); cyc();
    chk("ld pc", 64'(o_pc[0]), 64'h3000);
    chk("ld pc8", 64'(o_pc8[0]), 64'h3008);
    chk("ld tnew dec", 64'(o_tnew[0]), 1);
    chk("ld tnew nodec", 64'(o_tnew[1]), 2);
    chk("ld new exc", 64'(o_exc[0]), 4);

    load(1, 32'h3004, 1, 0, 5, 4, 64'h1234); cyc();
    chk("ld old exc wins", 64'(o_exc[0]), 5);
    chk("ld tnew sat", 64'(o_tnew[0]), 0);

    load(0, 32'h3006, 0, 3, 3, 2, 64'h55); cyc();
    chk("bubble exc", 64'(o_exc[0]), 0);
    chk("bubble tnew", 64'(o_tnew[0]), 2);

    load(1, 32'h3008, 0, 3, 0, 0, 64'hA5A5); cyc();
    stall = 1;
    for (int i = 0; i < 300; i++) begin
      load(i[0], $urandom, $urandom_range(0, 1), 2'($urandom), 5'($urandom), 5'($urandom),
           {$urandom, $urandom});
      cyc();
      if (i == 9) chk("stall cnt 10", 64'(o_cnt[0]), 10);
    end
    chk("stall cnt sat", 64'(o_cnt[0]), 255);
    chk("stall pc held", 64'(o_pc[0]), 64'h3008);
    chk("stall payload held", o_payload[0], 64'hA5A5);
    stall = 0; load(1, 32'h300C, 0, 1, 0, 0, 64'h7); cyc();
    chk("unstall cnt", 64'(o_cnt[0]), 0);

    req = 1; stall = 1; flush = 1; cyc();
    chk("req pc", 64'(o_pc[0]), 64'h4180);
    chk("req pc8", 64'(o_pc8[0]), 64'h4188);
    chk("req valid", 64'(o_valid[0]), 0);
    chk("req exc", 64'(o_exc[0]), 0);
    req = 0; stall = 0;

    load(1, 32'h3010, 1, 2, 1, 1, 64'hFF); cyc();
    chk("flush keep pc", 64'(o_pc[0]), 64'h3010);
    chk("flush keep bd", 64'(o_bd[0]), 1);
    chk("flush valid", 64'(o_valid[0]), 0);
    chk("flush zero pc", 64'(o_pc[1]), 0);
    chk("flush zero bd", 64'(o_bd[1]), 0);
    flush = 0;

    load(1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0); cyc();
    chk("pc8 wrap", 64'(o_pc8[0]), 0);
    load(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0); cyc();
    chk("pc8 wrap4", 64'(o_pc8[0]), 4);

    stall = 1; cyc(3);
    chk("mid stall cnt", 64'(o_cnt[0]), 3);
    reset = 1; cyc();
    chk("rst mid stall cnt", 64'(o_cnt[0]), 0);
    chk("rst mid stall pc", 64'(o_pc[0]), 0);
    reset = 0; stall = 0;

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      req   = ($urandom_range(0, 19) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      load($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1), 2'($urandom),
           ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0, 5'($urandom), {$urandom, $urandom});
      cyc();
    end
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
